// File: rtl/sh7034_ext_bus_bridge.sv
// sh7034_ext_bus_bridge: external-bus responder for the SH7034 core.
// Decodes chip-select areas 0-3 and maps each access onto one synchronous
// 16-bit memory port. Each area has its own number of wait states, and the
// bridge requests them by holding WAIT_N low. Read data is returned on DI.
// Optional build macro EXT_MEM_RDY_EN adds a MEM_RDY handshake input, which
// lets a variable-latency memory stretch the access.
module sh7034_ext_bus_bridge #(
  parameter int unsigned AREA0_WAIT = 2,
  parameter int unsigned AREA1_WAIT = 0,
  parameter int unsigned AREA2_WAIT = 1,
  parameter int unsigned AREA3_WAIT = 3,
  parameter int unsigned MEM_AW     = 20
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              CE_R,
  input  logic [26:0]       A,
  input  logic [15:0]       DO,
  output logic [15:0]       DI,
  input  logic [3:0]        CS_N,
  input  logic              RD_N,
  input  logic [1:0]        WE_N,
  output logic              WAIT_N,
  output logic [MEM_AW-1:0] MEM_A,
  output logic [15:0]       MEM_D,
  output logic [1:0]        MEM_WE,
  output logic              MEM_RD,
  input  logic [15:0]       MEM_Q
`ifdef EXT_MEM_RDY_EN
  ,
  input  logic              MEM_RDY
`endif
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t              state_reg, state_next;
  logic [3:0]          cnt_reg, cnt_next;
  logic                read_reg, read_next;
  logic                issued_reg, issued_next;
  logic                got_reg, got_next;
  logic                wait_n_reg, wait_n_next;
  logic [MEM_AW-1:0]   mem_a_reg, mem_a_next;
  logic [15:0]         mem_d_reg, mem_d_next;
  logic [1:0]          mem_we_reg, mem_we_next;
  logic                mem_rd_reg, mem_rd_next;
  logic [15:0]         di_reg, di_next;

  logic                strobe;
  logic                start;
  logic                released;
  logic [1:0]          area_sel;
  logic [3:0]          area_wait;
  logic [3:0]          cnt_dec;
  logic                mem_rdy_w;
  logic                data_ok;
  logic                finish;
  logic                unused_addr_bits;

  // Address bits above the memory window and the byte lane bit are not used.
  assign unused_addr_bits = ^{A[26:MEM_AW-1], A[0]};

  assign strobe   = ~RD_N | (WE_N != 2'b11);
  assign start    = ~(&CS_N) & strobe;
  assign released = (&CS_N) | (RD_N & (&WE_N));

`ifdef EXT_MEM_RDY_EN
  assign mem_rdy_w = MEM_RDY;
`else
  assign mem_rdy_w = 1'b1;
`endif

  // Chip-select priority encoder: lowest active index wins.
  always_comb begin
    area_sel = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!CS_N[i]) area_sel = 2'(i);
    end
  end

  // Per-area wait-state lookup.
  always_comb begin
    case (area_sel)
      2'd0:    area_wait = 4'(AREA0_WAIT);
      2'd1:    area_wait = 4'(AREA1_WAIT);
      2'd2:    area_wait = 4'(AREA2_WAIT);
      default: area_wait = 4'(AREA3_WAIT);
    endcase
  end

  // The access may end on the CE_R edge where the counter reaches zero,
  // but only once memory data is available (at least two CLKs after entry).
  assign cnt_dec = (cnt_reg != 4'd0) ? cnt_reg - 4'd1 : 4'd0;
  assign data_ok = issued_reg & (got_reg | mem_rdy_w);
  assign finish  = (state_reg == ACCESS) & CE_R & data_ok & (cnt_dec == 4'd0);

  // State register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic. A strobe release seen at completion skips DONE.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (CE_R && start) state_next = ACCESS;
      ACCESS:  if (finish) state_next = released ? IDLE : DONE;
      DONE:    if (CE_R && released) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output and datapath next values. The memory strobes default to 0,
  // so each one is a single-CLK pulse.
  always_comb begin
    cnt_next    = cnt_reg;
    read_next   = read_reg;
    issued_next = issued_reg;
    got_next    = got_reg;
    wait_n_next = wait_n_reg;
    mem_a_next  = mem_a_reg;
    mem_d_next  = mem_d_reg;
    di_next     = di_reg;
    mem_we_next = 2'b00;
    mem_rd_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (CE_R && start) begin
          mem_a_next  = {area_sel, A[MEM_AW-2:1]};
          mem_d_next  = DO;
          read_next   = ~RD_N;
          cnt_next    = area_wait;
          wait_n_next = (area_wait == 4'd0);
          issued_next = 1'b0;
          got_next    = 1'b0;
          mem_rd_next = ~RD_N;
          mem_we_next = RD_N ? ~WE_N : 2'b00;
        end
      end
      ACCESS: begin
        issued_next = 1'b1;
        if (CE_R) cnt_next = cnt_dec;
        if (issued_reg && mem_rdy_w && !got_reg) begin
          got_next = 1'b1;
          if (read_reg) di_next = MEM_Q;
        end
        if (finish) begin
          wait_n_next = 1'b1;
        end
`ifdef EXT_MEM_RDY_EN
        else if (issued_reg && !got_reg && !MEM_RDY) begin
          wait_n_next = 1'b0;
        end
`endif
      end
      default: ;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_reg    <= 4'd0;
      read_reg   <= 1'b0;
      issued_reg <= 1'b0;
      got_reg    <= 1'b0;
      wait_n_reg <= 1'b1;
      mem_a_reg  <= '0;
      mem_d_reg  <= 16'h0000;
      mem_we_reg <= 2'b00;
      mem_rd_reg <= 1'b0;
      di_reg     <= 16'h0000;
    end else begin
      cnt_reg    <= cnt_next;
      read_reg   <= read_next;
      issued_reg <= issued_next;
      got_reg    <= got_next;
      wait_n_reg <= wait_n_next;
      mem_a_reg  <= mem_a_next;
      mem_d_reg  <= mem_d_next;
      mem_we_reg <= mem_we_next;
      mem_rd_reg <= mem_rd_next;
      di_reg     <= di_next;
    end
  end

  assign DI     = di_reg;
  assign WAIT_N = wait_n_reg;
  assign MEM_A  = mem_a_reg;
  assign MEM_D  = mem_d_reg;
  assign MEM_WE = mem_we_reg;
  assign MEM_RD = mem_rd_reg;

endmodule

// File: tb/tb_sh7034_ext_bus_bridge.sv
// Directed testbench for sh7034_ext_bus_bridge (default build). The memory
// model returns rd_data one CLK after MEM_RD. CE_R toggles every CLK.
module tb_sh7034_ext_bus_bridge;
  localparam int MEM_AW = 20;

  logic              CLK = 1'b0;
  logic              RST_N = 1'b0;
  logic              CE_R = 1'b0;
  logic [26:0]       A = '0;
  logic [15:0]       DO = '0;
  logic [15:0]       DI;
  logic [3:0]        CS_N = 4'hF;
  logic              RD_N = 1'b1;
  logic [1:0]        WE_N = 2'b11;
  logic              WAIT_N;
  logic [MEM_AW-1:0] MEM_A;
  logic [15:0]       MEM_D;
  logic [1:0]        MEM_WE;
  logic              MEM_RD;
  logic [15:0]       MEM_Q = '0;
  logic              mem_rdy = 1'b1;
  logic [15:0]       rd_data = '0;

  int n_checks = 0;
  int n_pass = 0;

  int rd_cnt = 0, we_cnt = 0, wait_cnt = 0;
  logic [MEM_AW-1:0] last_a = '0, last_wa = '0;
  logic [1:0]        last_we = '0;
  logic [15:0]       last_d = '0, di_at_rise = '0;
  logic              prev_wait = 1'b1;
  int rd0, we0, w0;

  sh7034_ext_bus_bridge dut (
    .CLK(CLK), .RST_N(RST_N), .CE_R(CE_R), .A(A), .DO(DO), .DI(DI),
    .CS_N(CS_N), .RD_N(RD_N), .WE_N(WE_N), .WAIT_N(WAIT_N),
    .MEM_A(MEM_A), .MEM_D(MEM_D), .MEM_WE(MEM_WE), .MEM_RD(MEM_RD),
    .MEM_Q(MEM_Q)
`ifdef EXT_MEM_RDY_EN
    , .MEM_RDY(mem_rdy)
`endif
  );

  always #5 CLK = ~CLK;
  always @(negedge CLK) CE_R = ~CE_R;

  // Memory model: fixed one-CLK read latency.
  always @(posedge CLK) if (MEM_RD) MEM_Q <= rd_data;

  // Bus monitor, sampled on the falling edge.
  always @(negedge CLK) begin
    if (MEM_RD) begin
      rd_cnt = rd_cnt + 1;
      last_a = MEM_A;
    end
    if (MEM_WE != 2'b00) begin
      we_cnt  = we_cnt + 1;
      last_we = MEM_WE;
      last_d  = MEM_D;
      last_wa = MEM_A;
    end
    if (!WAIT_N) wait_cnt = wait_cnt + 1;
    if (WAIT_N && !prev_wait) di_at_rise = DI;
    prev_wait = WAIT_N;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
      $display("ok   %-14s got %h", tag, got);
    end else begin
      $display("FAIL %-14s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic snap();
    rd0 = rd_cnt;
    we0 = we_cnt;
    w0  = wait_cnt;
  endtask

  task automatic bus_start(input logic [3:0] cs, input logic rd, input logic [1:0] we,
                           input logic [26:0] addr, input logic [15:0] d);
    @(negedge CLK);
    CS_N = cs; RD_N = rd; WE_N = we; A = addr; DO = d;
  endtask

  task automatic bus_release();
    @(negedge CLK);
    CS_N = 4'hF; RD_N = 1'b1; WE_N = 2'b11;
    repeat (3) @(negedge CLK);
  endtask

  initial begin
    repeat (3) @(negedge CLK);
    check("rst_di", 32'(DI), 32'h0);
    check("rst_wait_n", 32'(WAIT_N), 32'h1);
    check("rst_mem_rd", 32'(MEM_RD), 32'h0);
    check("rst_mem_we", 32'(MEM_WE), 32'h0);
    check("rst_mem_a", 32'(MEM_A), 32'h0);
    RST_N = 1'b1;
    repeat (2) @(negedge CLK);

    // CS0 read, two wait states: WAIT_N low 4 CLK = 2 CE_R periods.
    snap(); rd_data = 16'h1234;
    bus_start(4'b1110, 1'b0, 2'b11, 27'h000100, 16'h0);
    repeat (12) @(negedge CLK);
    check("cs0_rd_pulses", 32'(rd_cnt - rd0), 32'd1);
    check("cs0_wait_clks", 32'(wait_cnt - w0), 32'd4);
    check("cs0_mem_a", 32'(last_a), 32'h00080);
    check("cs0_di_rise", 32'(di_at_rise), 32'h1234);
    repeat (10) @(negedge CLK);
    check("no_restart", 32'(rd_cnt - rd0), 32'd1);
    bus_release();

    // Release then re-assert: a second access occurs.
    snap(); rd_data = 16'h5678;
    bus_start(4'b1110, 1'b0, 2'b11, 27'h000100, 16'h0);
    repeat (12) @(negedge CLK);
    check("reassert_rd", 32'(rd_cnt - rd0), 32'd1);
    check("reassert_di", 32'(DI), 32'h5678);
    bus_release();

    // CS1 lower-byte write, zero wait.
    snap();
    bus_start(4'b1101, 1'b1, 2'b10, 27'h000000, 16'hABCD);
    repeat (12) @(negedge CLK);
    check("cs1_wait_clks", 32'(wait_cnt - w0), 32'd0);
    check("cs1_we_pulses", 32'(we_cnt - we0), 32'd1);
    check("cs1_mem_we", 32'(last_we), 32'h1);
    check("cs1_mem_d", 32'(last_d), 32'hABCD);
    check("cs1_mem_a", 32'(last_wa), 32'h40000);
    check("cs1_di_kept", 32'(DI), 32'h5678);
    bus_release();

    // CS0 and CS2 both low: area 0 wins.
    snap(); rd_data = 16'h9ABC;
    bus_start(4'b1010, 1'b0, 2'b11, 27'h000200, 16'h0);
    repeat (12) @(negedge CLK);
    check("prio_mem_a", 32'(last_a), 32'h00100);
    check("prio_wait", 32'(wait_cnt - w0), 32'd4);
    check("prio_di", 32'(DI), 32'h9ABC);
    bus_release();

    // CS3 read at the top of the window, three wait states.
    snap(); rd_data = 16'h0FED;
    bus_start(4'b0111, 1'b0, 2'b11, 27'h07FFFE, 16'h0);
    repeat (14) @(negedge CLK);
    check("cs3_mem_a", 32'(last_a), 32'hFFFFF);
    check("cs3_wait", 32'(wait_cnt - w0), 32'd6);
    check("cs3_di", 32'(DI), 32'h0FED);
    bus_release();

    // CS2 word write, one wait state; RD_N high, both byte strobes low.
    snap();
    bus_start(4'b1011, 1'b1, 2'b00, 27'h000002, 16'h55AA);
    repeat (12) @(negedge CLK);
    check("cs2_wait", 32'(wait_cnt - w0), 32'd2);
    check("cs2_mem_we", 32'(last_we), 32'h3);
    check("cs2_mem_a", 32'(last_wa), 32'h80001);
    check("cs2_mem_d", 32'(last_d), 32'h55AA);
    bus_release();

    // CPU abort: strobes dropped during ACCESS; access still completes.
    snap(); rd_data = 16'h4242;
    bus_start(4'b1110, 1'b0, 2'b11, 27'h000100, 16'h0);
    repeat (2) @(negedge CLK);
    CS_N = 4'hF; RD_N = 1'b1;
    repeat (10) @(negedge CLK);
    check("abort_rd", 32'(rd_cnt - rd0), 32'd1);
    check("abort_wait_n", 32'(WAIT_N), 32'h1);
    check("abort_di", 32'(DI), 32'h4242);

    // Reset asserted mid-access while WAIT_N is low.
    bus_start(4'b1110, 1'b1, 2'b00, 27'h000100, 16'hDEAD);
    repeat (2) @(negedge CLK);
    check("pre_rst_wait", 32'(WAIT_N), 32'h0);
    #1 RST_N = 1'b0;
    #1;
    check("arst_wait_n", 32'(WAIT_N), 32'h1);
    check("arst_mem_rd", 32'(MEM_RD), 32'h0);
    check("arst_mem_we", 32'(MEM_WE), 32'h0);
    check("arst_mem_a", 32'(MEM_A), 32'h0);
    check("arst_mem_d", 32'(MEM_D), 32'h0);
    check("arst_di", 32'(DI), 32'h0);
    CS_N = 4'hF; RD_N = 1'b1; WE_N = 2'b11;
    @(negedge CLK);
    RST_N = 1'b1;
    snap();
    repeat (10) @(negedge CLK);
    check("no_late_write", 32'(we_cnt - we0), 32'd0);

    // Normal access after reset: CS1 zero-wait read.
    snap(); rd_data = 16'h7777;
    bus_start(4'b1101, 1'b0, 2'b11, 27'h000010, 16'h0);
    repeat (12) @(negedge CLK);
    check("post_rd", 32'(rd_cnt - rd0), 32'd1);
    check("post_wait", 32'(wait_cnt - w0), 32'd0);
    check("post_di", 32'(DI), 32'h7777);
    check("post_mem_a", 32'(last_a), 32'h40008);
    bus_release();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
